// File: rtl/video_page_engine.sv
// Video page command engine: fill/copy/blit/select over a single-port 4-page RAM, owns scanout page pointers.
// Build option: define VIDEO_BLIT_VSYNC_EN to hold blits until the next vsync_start pulse.
module video_page_engine #(
    parameter int PAGE_PIXELS = 64000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_dst,
    input  logic [7:0]  cmd_src,
    input  logic [3:0]  cmd_color,
    input  logic        vsync_start,
    output logic [17:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wdata,
    input  logic [3:0]  mem_rdata,
    output logic [1:0]  display_page,
    output logic [1:0]  work_page,
    output logic        busy
);

    localparam logic [15:0] LAST_PIX = 16'(PAGE_PIXELS - 1);

    localparam logic [1:0] OP_FILL   = 2'd0;
    localparam logic [1:0] OP_COPY   = 2'd1;
    localparam logic [1:0] OP_BLIT   = 2'd2;
    localparam logic [1:0] OP_SELECT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        COPY_RD,
        COPY_WR,
        WAIT_VS,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  dst_pg, dst_n;
    logic [1:0]  src_pg, src_n;
    logic [3:0]  color, color_n;
    logic        blit_keep, keep_n;
    logic        blit_swap, swap_n;
    logic [1:0]  disp_q, disp_n;
    logic [1:0]  back_q, back_n;
    logic [1:0]  work_q, work_n;

    logic        blit_go, go_keep, go_swap;
    logic [1:0]  go_page;

    logic [17:0] addr_q, addr_n;
    logic        we_q, we_n;
    logic [3:0]  wdata_q, wdata_n;
    logic        ready_q, busy_q;

    function automatic logic [1:0] resolve(input logic [7:0] id,
                                           input logic [1:0] disp,
                                           input logic [1:0] back);
        if (id < 8'd4)
            return id[1:0];
        else if (id == 8'hFE)
            return disp;
        else if (id == 8'hFF)
            return back;
        else
            return 2'd0;
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dst_n   = dst_pg;
        src_n   = src_pg;
        color_n = color;
        keep_n  = blit_keep;
        swap_n  = blit_swap;
        disp_n  = disp_q;
        back_n  = back_q;
        work_n  = work_q;
        blit_go = 1'b0;
        go_keep = blit_keep;
        go_swap = blit_swap;
        go_page = dst_pg;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    dst_n   = resolve(cmd_dst, disp_q, back_q);
                    src_n   = resolve(cmd_src, disp_q, back_q);
                    color_n = cmd_color;
                    keep_n  = (cmd_dst == 8'hFE);
                    swap_n  = (cmd_dst == 8'hFF);
                    cnt_n   = '0;
                    case (cmd_op)
                        OP_FILL: state_n = FILL;
                        OP_COPY: state_n = COPY_RD;
                        OP_BLIT: begin
`ifdef VIDEO_BLIT_VSYNC_EN
                            state_n = WAIT_VS;
`else
                            blit_go = 1'b1;
                            go_keep = keep_n;
                            go_swap = swap_n;
                            go_page = dst_n;
                            state_n = DONE;
`endif
                        end
                        OP_SELECT: begin
                            work_n  = dst_n;
                            state_n = DONE;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            FILL: begin
                if (cnt == LAST_PIX)
                    state_n = DONE;
                else
                    cnt_n = cnt + 16'd1;
            end
            COPY_RD: state_n = COPY_WR;
            COPY_WR: begin
                if (cnt == LAST_PIX) begin
                    state_n = DONE;
                end else begin
                    cnt_n   = cnt + 16'd1;
                    state_n = COPY_RD;
                end
            end
            WAIT_VS: begin
                if (vsync_start) begin
                    blit_go = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Blit: 0xFF flips front/back, 0xFE leaves pointers alone, anything else retargets the front page.
        if (blit_go) begin
            if (go_swap) begin
                disp_n = back_q;
                back_n = disp_q;
            end else if (!go_keep) begin
                disp_n = go_page;
            end
        end
    end

    // Memory-port outputs are computed for the state being entered so they register alongside it.
    always_comb begin
        we_n    = 1'b0;
        addr_n  = '0;
        wdata_n = wdata_q;
        case (state_n)
            FILL: begin
                we_n    = 1'b1;
                addr_n  = {dst_n, cnt_n};
                wdata_n = color_n;
            end
            COPY_RD: addr_n = {src_n, cnt_n};
            COPY_WR: begin
                we_n   = 1'b1;
                addr_n = {dst_n, cnt_n};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            disp_q  <= 2'd2;
            back_q  <= 2'd1;
            work_q  <= 2'd2;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            disp_q  <= disp_n;
            back_q  <= back_n;
            work_q  <= work_n;
            addr_q  <= addr_n;
            we_q    <= we_n;
            wdata_q <= wdata_n;
            ready_q <= (state_n == IDLE);
            busy_q  <= (state_n != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        dst_pg    <= dst_n;
        src_pg    <= src_n;
        color     <= color_n;
        blit_keep <= keep_n;
        blit_swap <= swap_n;
    end

    assign cmd_ready    = ready_q;
    assign busy         = busy_q;
    assign mem_addr     = addr_q;
    assign mem_we       = we_q;
    // Copy data is only available the cycle after the read, so it is forwarded straight to the write port.
    assign mem_wdata    = (state == COPY_WR) ? mem_rdata : wdata_q;
    assign display_page = disp_q;
    assign work_page    = work_q;

endmodule

// File: tb/tb_video_page_engine.sv
// Scoreboard bench for video_page_engine: page-level reference model, queued expected writes, random commands.
module tb_video_page_engine;

    localparam int P = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_dst;
    logic [7:0]  cmd_src;
    logic [3:0]  cmd_color;
    logic        vsync_start;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;
    logic [1:0]  display_page;
    logic [1:0]  work_page;
    logic        busy;

    logic        pre_we;
    logic [17:0] pre_addr;
    logic [3:0]  pre_data;

    always #5 clk = ~clk;

    video_page_engine #(.PAGE_PIXELS(P)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_color(cmd_color),
        .vsync_start(vsync_start),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .display_page(display_page), .work_page(work_page), .busy(busy)
    );

    logic [3:0] ram [0:262143];
    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [17:0] a;
        logic [3:0]  d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_writes = 0;

    logic [3:0] mdl [4][P];
    int m_disp, m_back, m_work;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    function automatic int m_res(input logic [7:0] id);
        if (id < 8'd4) return int'(id);
        if (id == 8'hFE) return m_disp;
        if (id == 8'hFF) return m_back;
        return 0;
    endfunction

    task automatic model_cmd(input logic [1:0] op, input logic [7:0] dst,
                             input logic [7:0] src, input logic [3:0] color);
        int d, s, t;
        wr_t w;
        d = m_res(dst);
        s = m_res(src);
        case (op)
            2'd0: for (int i = 0; i < P; i++) begin
                w.a = 18'(d * 65536 + i);
                w.d = color;
                exp_q.push_back(w);
                mdl[d][i] = color;
            end
            2'd1: for (int i = 0; i < P; i++) begin
                w.a = 18'(d * 65536 + i);
                w.d = mdl[s][i];
                exp_q.push_back(w);
                mdl[d][i] = w.d;
            end
            2'd2: begin
                if (dst == 8'hFF) begin
                    t = m_disp; m_disp = m_back; m_back = t;
                end else if (dst != 8'hFE) begin
                    m_disp = d;
                end
            end
            default: m_work = d;
        endcase
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.a));
                check("wr_data", 32'(mem_wdata), 32'(mon_e.d));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] dst, input logic [7:0] src,
                         input logic [3:0] color, input bit vs_on_hs);
        int guard;
        bit r;
        guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_color = color;
        vsync_start = vs_on_hs;
        forever begin
            r = cmd_ready;
            @(posedge clk);
            if (r) break;
            guard++;
            if (guard > 1000) begin
                $display("FAIL issue_timeout");
                $fatal(1, "command never accepted");
            end
            @(negedge clk);
        end
        model_cmd(op, dst, src, color);
        #1;
        cmd_valid = 1'b0; vsync_start = 1'b0;
        cmd_op = 2'($urandom); cmd_dst = 8'($urandom); cmd_src = 8'($urandom); cmd_color = 4'($urandom);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmd_ready !== 1'b1 && n < 5000);
        if (cmd_ready !== 1'b1) fail_now("ready_timeout");
    endtask

    task automatic vs_pulse(input int delay);
        repeat (delay) @(negedge clk);
        @(negedge clk);
        vsync_start = 1'b1;
        @(negedge clk);
        vsync_start = 1'b0;
    endtask

    task automatic do_select(input logic [7:0] dst);
        issue(2'd3, dst, 8'h00, 4'h0, 1'b0);
        @(negedge clk);
        check("sel_work", 32'(work_page), 32'(m_work));
        check("sel_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("sel_ready_high", 32'(cmd_ready), 32'd1);
    endtask

    function automatic logic [7:0] rand_id();
        int r;
        r = $urandom_range(0, 7);
        if (r < 4) return 8'(r);
        if (r == 4) return 8'hFE;
        if (r == 5) return 8'hFF;
        return 8'($urandom_range(4, 253));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w0;
        logic [1:0] op;
        logic [7:0] dst, src;
        logic [3:0] col;

        reset = 1'b0; cmd_valid = 1'b0; vsync_start = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_src = '0; cmd_color = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        m_disp = 2; m_back = 1; m_work = 2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_disp", 32'(display_page), 32'd2);
        check("rst_work", 32'(work_page), 32'd2);
        reset = 1'b1;

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < P; i++) begin
                @(negedge clk);
                pre_we = 1'b1;
                pre_addr = 18'(p * 65536 + i);
                pre_data = 4'($urandom);
                mdl[p][i] = pre_data;
            end
        end
        @(negedge clk);
        pre_we = 1'b0;

        do_select(8'hFF);
        check("sel_ff_work", 32'(work_page), 32'd1);

        w0 = n_writes;
        issue(2'd0, 8'h00, 8'h00, 4'hA, 1'b0);
        wait_ready(n);
        check("fill_cycles", 32'(n), 32'(P + 2));
        check("fill_writes", 32'(n_writes - w0), 32'(P));
        check("fill_q_empty", 32'(exp_q.size()), 32'd0);

        w0 = n_writes;
        issue(2'd1, 8'h03, 8'h01, 4'h0, 1'b0);
        wait_ready(n);
        check("copy_cycles", 32'(n), 32'(2 * P + 2));
        check("copy_writes", 32'(n_writes - w0), 32'(P));
        check("copy_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef VIDEO_BLIT_VSYNC_EN
        issue(2'd2, 8'hFF, 8'h00, 4'h0, 1'b1);
        repeat (9) @(negedge clk);
        check("blit_wait_disp", 32'(display_page), 32'd2);
        check("blit_wait_busy", 32'(busy), 32'd1);
        vs_pulse(0);
        check("blit_vs_disp", 32'(display_page), 32'(m_disp));
        wait_ready(n);
        check("blit_done_cycles", 32'(n), 32'd1);
`else
        issue(2'd2, 8'hFF, 8'h00, 4'h0, 1'b0);
        @(negedge clk);
        check("blit_disp", 32'(display_page), 32'(m_disp));
        check("blit_busy", 32'(busy), 32'd1);
        wait_ready(n);
        check("blit_done_cycles", 32'(n), 32'd1);
`endif
        check("blit_disp_is_1", 32'(display_page), 32'd1);
        do_select(8'hFF);
        check("sel_after_swap", 32'(work_page), 32'd2);

        issue(2'd2, 8'h55, 8'h00, 4'h0, 1'b0);
`ifdef VIDEO_BLIT_VSYNC_EN
        vs_pulse(3);
`endif
        wait_ready(n);
        check("blit55_disp", 32'(display_page), 32'd0);
        issue(2'd0, 8'hFE, 8'h00, 4'h5, 1'b0);
        wait_ready(n);
        check("fill_fe_cycles", 32'(n), 32'(P + 2));
        check("fill_fe_q_empty", 32'(exp_q.size()), 32'd0);

        for (int k = 0; k < 25; k++) begin
            op  = 2'($urandom_range(0, 3));
            dst = rand_id();
            src = rand_id();
            col = 4'($urandom);
            issue(op, dst, src, col, 1'b0);
`ifdef VIDEO_BLIT_VSYNC_EN
            if (op == 2'd2) vs_pulse($urandom_range(0, 4));
`endif
            if ($urandom_range(0, 1) == 0) begin
                wait_ready(n);
                check("rnd_disp", 32'(display_page), 32'(m_disp));
                check("rnd_work", 32'(work_page), 32'(m_work));
            end
        end
        wait_ready(n);
        check("rnd_q_empty", 32'(exp_q.size()), 32'd0);
        check("rnd_final_disp", 32'(display_page), 32'(m_disp));
        check("rnd_final_work", 32'(work_page), 32'(m_work));

        issue(2'd0, 8'h02, 8'h00, 4'h7, 1'b0);
        repeat (P / 2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_disp", 32'(display_page), 32'd2);
        check("midrst_work", 32'(work_page), 32'd2);
        reset = 1'b1;
        m_disp = 2; m_back = 1; m_work = 2;
        repeat (3) @(negedge clk);
        do_select(8'hFF);
        check("midrst_back", 32'(work_page), 32'd1);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
